timer_bank: RTL and testbench
=============================

# timer_bank

Parametrised system timer on the IO address space; the next generation of the single-compare machine timer. It provides a WIDTH-bit free-running time counter with a programmable prescaler and NCMP independent compare channels. Each channel has sticky pending status, a per-channel interrupt enable and write-1-to-clear acknowledge. A read-coherent shadow of the upper time word is included. It sits on the core's IO bus and drives the machine timer interrupt lines.

## Interface
- WIDTH, 64: time counter and compare width; legal values 32 or 64.
- NCMP, 2: number of compare channels; legal values 1..6.
- PRESC_W, 16: prescaler divisor width; legal values 1..16.
- clk  in  1  system clock; all state updates on rising edge.
- resetb  in  1  asynchronous active-low reset.
- io_addr  in  4  word index (byte address bits [5:2]) within the timer window.
- io_we  in  1  write strobe for io_din to the addressed word.
- io_re  in  1  read strobe; used only for the time-low snapshot side effect.
- io_din  in  32  write data.
- io_dout  out  32  combinational read data for io_addr.
- irq  out  NCMP  per-channel interrupt, pending[k] & ie[k].
- irq_any  out  1  OR of irq.

## Operation
- Register map by word index:
  - 0: TIME_LO.
  - 1: TIME_HI (read returns shadow).
  - 2: CTRL: [0] EN, [13:8] IE[5:0], [31:16] PRESC.
  - 3: STATUS: [5:0] pending, write-1-to-clear.
  - 4+2k: CMPk_LO.
  - 5+2k: CMPk_HI.
- Unmapped words, channel words with k≥NCMP, and HI words when WIDTH=32:
  - reads return 0;
  - writes are ignored.
- CTRL bits and IE bits for channels k≥NCMP are read-as-zero.
- PRESC bits above PRESC_W are read-as-zero.
- Prescaler:
  - pcnt counts 0..PRESC while EN=1;
  - tick asserts on the cycle pcnt==PRESC, and pcnt returns to 0;
  - PRESC=0 ticks every cycle.
- On tick, time increments by 1 modulo 2^WIDTH; all-ones wraps to 0 without a fault.
- EN=0: time and pcnt hold.
- A write to CTRL resets pcnt to 0.
- A write to TIME_LO or TIME_HI:
  - loads that half;
  - suppresses any increment in that cycle;
  - leaves the other half unchanged;
  - leaves pcnt untouched.
- Snapshot: io_re with io_addr=0 latches the current time[63:32] into time_hi_shadow. Reads of word 1 return the shadow, not the live value.
- Compare:
  - each cycle, for each k, if time ≥ cmp[k] (unsigned, registered values), pending[k] sets;
  - pending[k] is sticky.
- pending[k] clears on either of:
  - STATUS write with io_din[k]=1;
  - any write to CMPk_LO or CMPk_HI.
- Clear beats set in the write cycle. If the condition still holds afterwards, pending re-sets on the following cycle.
- IE gates irq only; pending is recorded regardless of IE.
- Reset values:
  - time 0;
  - time_hi_shadow 0;
  - pcnt 0;
  - CTRL: EN=1, IE=all ones, PRESC=0;
  - every cmp all ones;
  - pending 0;
  - irq 0;
  - irq_any 0.
- Reset mid-count or mid-write discards the cycle's update; all registers take their reset values immediately.

## Timing
- Writes take effect at the rising edge where io_we=1; a read in the next cycle returns the new value.
- io_dout is combinational from the current registers in the same cycle as io_addr. There is no read latency.
- Compare latency:
  - time reaches cmp[k] at edge t;
  - pending[k] sets at edge t+1;
  - irq[k] is high from t+1, combinational from registers.
- The snapshot is taken at the edge with io_re=1 and io_addr=0. A word-1 read in any later cycle sees it.
- Back-to-back writes are accepted every cycle; there is no stall and no handshake.
- A simultaneous tick and TIME write resolves to the written value.

## Test plan
- Reset -> read all words:
  - time=0;
  - CTRL=0x00003F01 masked to NCMP (0x00000301 for NCMP=2);
  - cmp=0xFFFFFFFF;
  - STATUS=0;
  - irq=0.
- PRESC=3, EN=1:
  - time increments once every 4 cycles;
  - a CTRL rewrite restarts the 4-cycle phase.
- Write TIME_LO=0xFFFFFFFE, TIME_HI=0xFFFFFFFF, PRESC=0:
  - time wraps to 0 after 2 cycles;
  - no irq with cmp=all ones until time reaches all ones.
- CMP0=20, time=0, PRESC=0:
  - pending[0] and irq[0] rise the cycle after time=20, and stay high past time=21;
  - STATUS write 0x1 drops pending for one cycle, then it re-sets because time≥20;
  - write CMP0_LO=100 -> pending stays clear until time≥100.
- IE[1]=0 with channel 1 matching -> STATUS[1]=1, irq[1]=0, irq_any reflects channel 0 only.
- Write time=0x00000001_FFFFFFFF, read TIME_LO with io_re, wait 3 ticks, read TIME_HI -> returns 0x00000001, not 0x00000002.

Source files
------------

// File: rtl/timer_bank.sv
// System timer: prescaled free-running WIDTH-bit time counter, NCMP compare channels
// with sticky pending, per-channel interrupt enable, and a coherent upper-word snapshot.
module timer_bank #(
  parameter int WIDTH   = 64,
  parameter int NCMP    = 2,
  parameter int PRESC_W = 16
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic [3:0]      io_addr,
  input  logic            io_we,
  input  logic            io_re,
  input  logic [31:0]     io_din,
  output logic [31:0]     io_dout,
  output logic [NCMP-1:0] irq,
  output logic            irq_any
);

  logic [WIDTH-1:0]   time_q, time_d, time_load;
  logic [31:0]        time_hi_shadow_q, time_hi_shadow_d, time_hi_live;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d, presc_q, presc_d;
  logic               en_q, en_d;
  logic [NCMP-1:0]    ie_q, ie_d, pending;
  logic [31:0]        cmp_rd_lo [NCMP];
  logic [31:0]        cmp_rd_hi [NCMP];
  logic [31:0]        ctrl_rd, status_rd;
  logic               wr_time_lo, wr_time_hi, wr_ctrl, wr_status, snap, tick;

  assign wr_time_lo = io_we && (io_addr == 4'd0);
  assign wr_time_hi = io_we && (io_addr == 4'd1) && (WIDTH == 64);
  assign wr_ctrl    = io_we && (io_addr == 4'd2);
  assign wr_status  = io_we && (io_addr == 4'd3);
  assign snap       = io_re && (io_addr == 4'd0);
  assign tick       = en_q && (pcnt_q == presc_q);

  // Narrow timers have no upper word: HI writes vanish and the shadow stays zero.
  generate
    if (WIDTH == 64) begin : g_time64
      assign time_hi_live = time_q[WIDTH-1:32];
      assign time_load    = {wr_time_hi ? io_din : time_q[WIDTH-1:32],
                             wr_time_lo ? io_din : time_q[31:0]};
    end else begin : g_time32
      assign time_hi_live = '0;
      assign time_load    = wr_time_lo ? io_din : time_q[31:0];
    end
  endgenerate

  always_comb begin
    time_d = time_q;
    if (wr_time_lo || wr_time_hi) begin
      time_d = time_load;
    end else if (tick) begin
      time_d = time_q + WIDTH'(1);
    end
  end

  always_comb begin
    pcnt_d = pcnt_q;
    if (wr_ctrl || tick) begin
      pcnt_d = '0;
    end else if (en_q) begin
      pcnt_d = pcnt_q + PRESC_W'(1);
    end
  end

  always_comb begin
    en_d    = en_q;
    ie_d    = ie_q;
    presc_d = presc_q;
    if (wr_ctrl) begin
      en_d    = io_din[0];
      ie_d    = io_din[8 +: NCMP];
      presc_d = io_din[16 +: PRESC_W];
    end
  end

  assign time_hi_shadow_d = snap ? time_hi_live : time_hi_shadow_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      time_q           <= '0;
      time_hi_shadow_q <= '0;
      pcnt_q           <= '0;
      en_q             <= 1'b1;
      ie_q             <= '1;
      presc_q          <= '0;
    end else begin
      time_q           <= time_d;
      time_hi_shadow_q <= time_hi_shadow_d;
      pcnt_q           <= pcnt_d;
      en_q             <= en_d;
      ie_q             <= ie_d;
      presc_q          <= presc_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCMP; gi++) begin : g_ch
      localparam logic [3:0] LO_IDX = 4'(4 + 2 * gi);
      logic [WIDTH-1:0] cmp_q, cmp_d;
      logic             pend_q, pend_d, wr_lo, wr_hi, clr;

      assign wr_lo = io_we && (io_addr == LO_IDX);

      if (WIDTH == 64) begin : g_hi
        localparam logic [3:0] HI_IDX = 4'(5 + 2 * gi);
        assign wr_hi          = io_we && (io_addr == HI_IDX);
        assign cmp_d          = {wr_hi ? io_din : cmp_q[WIDTH-1:32],
                                 wr_lo ? io_din : cmp_q[31:0]};
        assign cmp_rd_hi[gi]  = cmp_q[WIDTH-1:32];
      end else begin : g_nohi
        assign wr_hi          = 1'b0;
        assign cmp_d          = wr_lo ? io_din : cmp_q[31:0];
        assign cmp_rd_hi[gi]  = '0;
      end

      assign cmp_rd_lo[gi] = cmp_q[31:0];
      // Clear wins over a same-cycle match; a persisting match re-sets one cycle later.
      assign clr           = (wr_status && io_din[gi]) || wr_lo || wr_hi;
      assign pend_d        = (pend_q || (time_q >= cmp_q)) && !clr;
      assign pending[gi]   = pend_q;

      always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
          cmp_q  <= '1;
          pend_q <= 1'b0;
        end else begin
          cmp_q  <= cmp_d;
          pend_q <= pend_d;
        end
      end
    end
  endgenerate

  assign ctrl_rd   = {16'(presc_q), 2'b00, 6'(ie_q), 7'b0000000, en_q};
  assign status_rd = {26'd0, 6'(pending)};

  always_comb begin
    io_dout = '0;
    case (io_addr)
      4'd0:    io_dout = time_q[31:0];
      4'd1:    io_dout = time_hi_shadow_q;
      4'd2:    io_dout = ctrl_rd;
      4'd3:    io_dout = status_rd;
      default: begin
        for (int k = 0; k < NCMP; k++) begin
          if (io_addr == 4'(4 + 2 * k)) io_dout = cmp_rd_lo[k];
          if (io_addr == 4'(5 + 2 * k)) io_dout = cmp_rd_hi[k];
        end
      end
    endcase
  end

  assign irq     = pending & ie_q;
  assign irq_any = |irq;

endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank (WIDTH=64, NCMP=2): directed scenarios then random bus traffic,
// all compared against a cycle-level behavioural model of the timer.
module tb_timer_bank;
  logic        clk = 1'b0;
  logic        resetb;
  logic [3:0]  io_addr;
  logic        io_we, io_re;
  logic [31:0] io_din, io_dout;
  logic [1:0]  irq;
  logic        irq_any;

  int n_checks = 0;
  int n_errors = 0;

  timer_bank #(.WIDTH(64), .NCMP(2), .PRESC_W(16)) dut (
    .clk(clk), .resetb(resetb), .io_addr(io_addr), .io_we(io_we), .io_re(io_re),
    .io_din(io_din), .io_dout(io_dout), .irq(irq), .irq_any(irq_any)
  );

  always #10 clk = ~clk;

  // Behavioural model state
  longint unsigned m_time;
  longint unsigned m_cmp [2];
  bit [31:0]       m_shadow;
  bit [15:0]       m_pcnt, m_presc;
  bit              m_en;
  bit [1:0]        m_ie, m_pend;

  function automatic void model_reset();
    m_time   = 0;
    m_shadow = 0;
    m_pcnt   = 0;
    m_en     = 1'b1;
    m_ie     = 2'b11;
    m_presc  = 0;
    m_pend   = 0;
    for (int k = 0; k < 2; k++) m_cmp[k] = 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic bit [31:0] model_read(input bit [3:0] a);
    longint unsigned c;
    case (a)
      4'd0: return m_time[31:0];
      4'd1: return m_shadow;
      4'd2: return {m_presc, 2'b00, 4'b0000, m_ie, 7'b0000000, m_en};
      4'd3: return {30'd0, m_pend};
      4'd4, 4'd5, 4'd6, 4'd7: begin
        c = m_cmp[(a - 4) / 2];
        return a[0] ? c[63:32] : c[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_step(input bit [3:0] a, input bit we, input bit re,
                                     input bit [31:0] d);
    bit              tick;
    longint unsigned t_new, c;
    bit [1:0]        p_new;
    tick = m_en && (m_pcnt == m_presc);
    for (int k = 0; k < 2; k++) p_new[k] = m_pend[k] | (m_time >= m_cmp[k]);
    t_new = m_time;
    if (we && a == 4'd0)      t_new[31:0]  = d;
    else if (we && a == 4'd1) t_new[63:32] = d;
    else if (tick)            t_new = m_time + 1;
    if (re && a == 4'd0) m_shadow = m_time[63:32];
    if (we && a == 4'd2) begin
      m_pcnt  = 0;
      m_en    = d[0];
      m_ie    = d[9:8];
      m_presc = d[31:16];
    end else if (tick) begin
      m_pcnt = 0;
    end else if (m_en) begin
      m_pcnt = m_pcnt + 16'd1;
    end
    if (we && a == 4'd3) p_new = p_new & ~d[1:0];
    for (int k = 0; k < 2; k++) begin
      if (we && (a == 4 + 2 * k || a == 5 + 2 * k)) begin
        p_new[k] = 1'b0;
        c = m_cmp[k];
        if (a[0]) c[63:32] = d;
        else      c[31:0]  = d;
        m_cmp[k] = c;
      end
    end
    m_time = t_new;
    m_pend = p_new;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input bit [3:0] a, input string tag, input logic [31:0] exp);
    io_addr = a;
    #1;
    chk(tag, io_dout, exp);
  endtask

  task automatic rdm(input bit [3:0] a, input string tag);
    rd(a, tag, model_read(a));
  endtask

  // One bus cycle: drive, clock, advance model, check interrupt outputs.
  task automatic cyc(input bit [3:0] a, input bit we, input bit re, input bit [31:0] d);
    io_addr = a;
    io_we   = we;
    io_re   = re;
    io_din  = d;
    @(posedge clk);
    model_step(a, we, re, d);
    #1;
    io_we = 1'b0;
    io_re = 1'b0;
    $display("cyc addr=%0d we=%0b re=%0b din=%08h irq=%b", a, we, re, d, irq);
    chk("irq", 32'(irq), 32'(m_pend & m_ie));
    chk("irq_any", 32'(irq_any), 32'(|(m_pend & m_ie)));
  endtask

  task automatic idle();
    cyc(4'd0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] base, d;
    bit [3:0]  a;
    bit        we, re;
    int        guard;

    resetb = 1'b0; io_addr = 0; io_we = 0; io_re = 0; io_din = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_irq_any", 32'(irq_any), 32'd0);
    for (int i = 0; i < 16; i++) rdm(4'(i), "rst_word");
    rd(4'd2, "rst_ctrl_const", 32'h0000_0301);
    resetb = 1'b1;

    // Prescaler 3: one increment per 4 cycles, CTRL rewrite restarts the phase
    cyc(4'd2, 1'b1, 1'b0, 32'h0003_0301);
    base = m_time[31:0];
    repeat (8) begin idle(); rdm(4'd0, "presc_time"); end
    rd(4'd0, "presc_4cyc", base + 32'd2);
    idle(); idle();
    cyc(4'd2, 1'b1, 1'b0, 32'h0003_0301);
    base = m_time[31:0];
    repeat (3) begin idle(); rd(4'd0, "presc_restart_hold", base); end
    idle();
    rd(4'd0, "presc_restart_tick", base + 32'd1);

    // Wrap through all-ones
    cyc(4'd2, 1'b1, 1'b0, 32'h0000_0301);
    cyc(4'd0, 1'b1, 1'b0, 32'hFFFF_FFFE);
    cyc(4'd1, 1'b1, 1'b0, 32'hFFFF_FFFF);
    rd(4'd0, "wrap_load", 32'hFFFF_FFFE);
    chk("wrap_no_irq_load", 32'(irq), 32'd0);
    idle();
    rd(4'd0, "wrap_allones", 32'hFFFF_FFFF);
    chk("wrap_no_irq_early", 32'(irq), 32'd0);
    idle();
    rd(4'd0, "wrap_zero", 32'd0);
    chk("wrap_irq_at_ones", 32'(irq), 32'd3);
    cyc(4'd3, 1'b1, 1'b0, 32'd3);
    rd(4'd3, "wrap_status_clr", 32'd0);

    // Channel 0 compare at 20, clear/re-set, then move compare to 100
    cyc(4'd4, 1'b1, 1'b0, 32'd20);
    cyc(4'd5, 1'b1, 1'b0, 32'd0);
    cyc(4'd1, 1'b1, 1'b0, 32'd0);
    cyc(4'd0, 1'b1, 1'b0, 32'd0);
    for (int i = 1; i <= 25; i++) begin
      idle();
      chk("cmp0_rise", 32'(irq[0]), (i >= 21) ? 32'd1 : 32'd0);
    end
    cyc(4'd3, 1'b1, 1'b0, 32'd1);
    rd(4'd3, "cmp0_status_clr", 32'd0);
    chk("cmp0_irq_clr", 32'(irq[0]), 32'd0);
    idle();
    rd(4'd3, "cmp0_reset_again", 32'd1);
    cyc(4'd4, 1'b1, 1'b0, 32'd100);
    rd(4'd3, "cmp0_rewrite_clr", 32'd0);
    guard = 0;
    while (m_time < 100 && guard < 200) begin
      idle();
      chk("cmp0_wait100", 32'(irq[0]), 32'd0);
      guard++;
    end
    chk("cmp0_wait_bound", 32'(guard < 200), 32'd1);
    idle();
    chk("cmp0_at_100", 32'(irq[0]), 32'd1);

    // IE[1]=0: pending recorded, interrupt masked
    cyc(4'd2, 1'b1, 1'b0, 32'h0000_0101);
    cyc(4'd7, 1'b1, 1'b0, 32'd0);
    cyc(4'd6, 1'b1, 1'b0, 32'd5);
    idle(); idle();
    rd(4'd3, "ie_status", 32'd3);
    chk("ie_irq_masked", 32'(irq), 32'd1);
    chk("ie_irq_any", 32'(irq_any), 32'd1);
    cyc(4'd4, 1'b1, 1'b0, 32'hFFFF_FFFF);
    rd(4'd3, "ie_status_ch1", 32'd2);
    chk("ie_any_ch1_masked", 32'(irq_any), 32'd0);

    // Snapshot coherence across a carry into the upper word
    cyc(4'd2, 1'b1, 1'b0, 32'h0000_0301);
    cyc(4'd1, 1'b1, 1'b0, 32'd1);
    cyc(4'd0, 1'b1, 1'b0, 32'hFFFF_FFFF);
    cyc(4'd0, 1'b0, 1'b1, 32'd0);
    repeat (3) idle();
    rd(4'd1, "snap_hi", 32'd1);
    rd(4'd0, "snap_lo_live", 32'd3);

    // Asynchronous reset with a write pending on the bus
    io_addr = 4'd0; io_din = 32'h1234_5678; io_we = 1'b1;
    resetb  = 1'b0;
    model_reset();
    rd(4'd2, "rst_async_ctrl", 32'h0000_0301);
    @(posedge clk);
    #1;
    rd(4'd0, "rst_mid_time", 32'd0);
    rd(4'd4, "rst_mid_cmp", 32'hFFFF_FFFF);
    rd(4'd3, "rst_mid_status", 32'd0);
    chk("rst_mid_irq", 32'(irq), 32'd0);
    io_we  = 1'b0;
    resetb = 1'b1;

    // Random bus traffic against the model
    for (int n = 0; n < 400; n++) begin
      a  = 4'($urandom_range(0, 15));
      we = ($urandom_range(0, 99) >= 55);
      re = 1'($urandom_range(0, 1));
      d  = $urandom;
      if (we) begin
        case (a)
          4'd2:               d = {16'($urandom_range(0, 3)), 6'd0, d[9:8], 7'd0,
                                   ($urandom_range(0, 7) != 0)};
          4'd1, 4'd5, 4'd7:   d = 32'($urandom_range(0, 2));
          default:            ;
        endcase
      end
      cyc(a, we, re, d);
      rdm(4'($urandom_range(0, 15)), "rand_rd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
